// File: rtl/serial_tx_pkg.sv
// Shared types and frame constants for the serial byte-frame transmitter.
// Optional feature macro: SERIAL_TX_PARITY_EN adds an even-parity bit after the data bits.
package serial_tx_pkg;

    localparam int unsigned FRAME_DATA_BITS = 8;
    localparam int unsigned BIT_IDX_W       = 3;
    localparam logic        START_BIT       = 1'b0;
    localparam logic        STOP_BIT        = 1'b1;
    localparam logic        IDLE_LEVEL      = 1'b1;

`ifdef SERIAL_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3,
        ST_PARITY = 3'd4
    } tx_state_e;

    // Even parity: XOR of all data bits.
    function automatic logic even_parity(input logic [FRAME_DATA_BITS-1:0] data);
        return ^data;
    endfunction
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;
`endif

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past last_grant and wraps.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any_req
);

    // Walk offsets 1..NUM_REQ from last_grant; the first valid requester wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_req   = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!any_req && req[i] && (i == ((32'(last_grant) + k) % NUM_REQ))) begin
                    any_req   = 1'b1;
                    grant[i]  = 1'b1;
                    grant_idx = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/serial_tx_arbiter.sv
// Shares one idle-high serial byte-frame transmitter among NUM_REQ producers.
// Optional feature macro: SERIAL_TX_PARITY_EN inserts an even-parity bit before stop.
module serial_tx_arbiter
    import serial_tx_pkg::*;
#(
    parameter int unsigned  NUM_REQ    = 4,
    parameter int unsigned  BIT_CYCLES = 1,
    localparam int unsigned IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*8-1:0]         req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         tx_line,
    output logic                         busy,
    output logic [IDX_W-1:0]             grant_id
);

    localparam int unsigned         CNT_W     = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(BIT_CYCLES - 1);
    localparam logic [IDX_W-1:0]    GRANT_RST = IDX_W'(NUM_REQ - 1);
    localparam logic [BIT_IDX_W-1:0] IDX_LAST = BIT_IDX_W'(FRAME_DATA_BITS - 1);

    tx_state_e                    state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [BIT_IDX_W-1:0]         idx_q, idx_d;
    logic [FRAME_DATA_BITS-1:0]   shift_q, shift_d;
    logic [IDX_W-1:0]             last_grant_q, last_grant_d;
    logic [IDX_W-1:0]             grant_id_q, grant_id_d;
    logic                         tx_q, tx_d;
    logic                         busy_q, busy_d;

    logic [NUM_REQ-1:0]           arb_grant;
    logic [IDX_W-1:0]             arb_idx;
    logic                         arb_any;
    logic                         bit_end;
    logic                         win;
    logic                         accept;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .grant      (arb_grant),
        .grant_idx  (arb_idx),
        .any_req    (arb_any)
    );

    // Accept window: any idle cycle, or the last stop cycle for gapless back-to-back frames.
    assign bit_end   = (cnt_q == CNT_LAST);
    assign win       = !rst && ((state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_end));
    assign accept    = win && arb_any;
    assign req_ready = win ? arb_grant : '0;

    // Frame state register and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            last_grant_q <= GRANT_RST;
            grant_id_q   <= '0;
            tx_q         <= IDLE_LEVEL;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
        end
    end

    // Next-state, bit timing and next line level (derived from the next state).
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        shift_d      = shift_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        tx_d         = IDLE_LEVEL;
        busy_d       = 1'b0;

        if (accept) begin
            state_d      = ST_START;
            cnt_d        = '0;
            idx_d        = '0;
            last_grant_d = arb_idx;
            grant_id_d   = arb_idx;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (arb_grant[i]) begin
                    shift_d = req_data[i*FRAME_DATA_BITS +: FRAME_DATA_BITS];
                end
            end
        end else begin
            case (state_q)
                ST_START: begin
                    if (bit_end) begin
                        state_d = ST_DATA;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        cnt_d = '0;
                        if (idx_q == IDX_LAST) begin
`ifdef SERIAL_TX_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_STOP;
`endif
                        end else begin
                            idx_d = idx_q + BIT_IDX_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
`ifdef SERIAL_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_end) begin
                        state_d = ST_STOP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_end) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end

        case (state_d)
            ST_START:  tx_d = START_BIT;
            ST_DATA:   tx_d = shift_d[idx_d];
`ifdef SERIAL_TX_PARITY_EN
            ST_PARITY: tx_d = even_parity(shift_d);
`endif
            ST_STOP:   tx_d = STOP_BIT;
            default:   tx_d = IDLE_LEVEL;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    assign tx_line  = tx_q;
    assign busy     = busy_q;
    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Self-checking bench for serial_tx_arbiter: a frame receiver checks decoded bytes
// against a queue of expected (requester, byte) pairs pushed when stimulus is set up.
module tb_serial_tx_arbiter;

`ifdef SERIAL_TX_PARITY_EN
    localparam int FL = 11;
`else
    localparam int FL = 10;
`endif
    localparam int N       = 4;
    localparam int SLOW_BC = 3;

    typedef struct {
        int         id;
        logic [7:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        tx_line;
    logic        busy;
    logic [1:0]  grant_id;

    logic        s_rst;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        s_tx;
    logic        s_busy;
    logic        s_gid;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    exp_t       exp_q[$];
    logic [7:0] src_q[N][$];
    int         acc_id_q[$];
    int         acc_cyc_q[$];
    int         rx_start_q[$];

    int         rx_cnt = 0;
    int         rx_start = 0;
    logic [7:0] rx_byte = 8'h00;
    logic [1:0] rx_gid = 2'b00;
    logic       rx_par = 1'b0;

    serial_tx_arbiter #(.NUM_REQ(4), .BIT_CYCLES(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx_line   (tx_line),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    serial_tx_arbiter #(.NUM_REQ(1), .BIT_CYCLES(SLOW_BC)) dut_s (
        .clk       (clk),
        .rst       (s_rst),
        .req_valid (s_valid),
        .req_data  (s_data),
        .req_ready (s_ready),
        .tx_line   (s_tx),
        .busy      (s_busy),
        .grant_id  (s_gid)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = (src_q[i].size() != 0);
            req_data[8*i +: 8] = (src_q[i].size() != 0) ? src_q[i][0] : 8'h00;
        end
    endtask

    // Receiver model for the main DUT (one bit per cycle), sampled at the falling edge.
    task automatic mon_sample();
        exp_t e;
        if (rst) begin
            rx_cnt = 0;
        end else if (rx_cnt == 0) begin
            if (tx_line === 1'b0) begin
                rx_cnt   = 1;
                rx_start = cyc;
                rx_gid   = grant_id;
                n_checks++;
                if (busy !== 1'b1) begin
                    n_errors++;
                    $display("FAIL busy_at_start: busy=%b required 1 (cycle %0d)", busy, cyc);
                end
            end else begin
                n_checks++;
                if (tx_line !== 1'b1 || busy !== 1'b0) begin
                    n_errors++;
                    $display("FAIL idle_line: tx_line=%b busy=%b required 1/0 (cycle %0d)", tx_line, busy, cyc);
                end
            end
        end else if (rx_cnt <= 8) begin
            rx_byte[3'(rx_cnt - 1)] = tx_line;
            rx_cnt++;
`ifdef SERIAL_TX_PARITY_EN
        end else if (rx_cnt == 9) begin
            rx_par = tx_line;
            rx_cnt++;
`endif
        end else begin
            rx_cnt = 0;
            rx_start_q.push_back(rx_start);
            n_checks++;
            if (tx_line !== 1'b1 || busy !== 1'b1) begin
                n_errors++;
                $display("FAIL stop_bit: tx_line=%b busy=%b required 1/1 (cycle %0d)", tx_line, busy, cyc);
            end
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_frame: byte=%h grant_id=%0d with none expected", rx_byte, rx_gid);
            end else begin
                e = exp_q.pop_front();
                if (rx_byte !== e.data || rx_gid !== 2'(e.id)) begin
                    n_errors++;
                    $display("FAIL frame: got byte=%h id=%0d required byte=%h id=%0d", rx_byte, rx_gid, e.data, e.id);
                end
`ifdef SERIAL_TX_PARITY_EN
                n_checks++;
                if (rx_par !== ^e.data) begin
                    n_errors++;
                    $display("FAIL parity_bit: got %b required %b for byte %h", rx_par, ^e.data, e.data);
                end
`endif
            end
        end
    endtask

    // One clock of the main DUT: sample mid-cycle, record handshakes, update producers.
    task automatic step();
        logic [3:0] hs;
        @(negedge clk);
        mon_sample();
        n_checks++;
        if (!$onehot0(req_ready)) begin
            n_errors++;
            $display("FAIL ready_onehot: req_ready=%b required at most one bit", req_ready);
        end
        hs = req_valid & req_ready;
        for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
                acc_id_q.push_back(i);
                acc_cyc_q.push_back(cyc);
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs[i]) void'(src_q[i].pop_front());
        end
        drive_inputs();
    endtask

    task automatic wait_exp_empty(input int bound, input string name);
        int k = 0;
        while (exp_q.size() != 0 && k < bound) begin
            step();
            k++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: %0d frames outstanding after %0d cycles, required 0", name, exp_q.size(), bound);
            exp_q.delete();
        end
    endtask

    task automatic clear_logs();
        acc_id_q.delete();
        acc_cyc_q.delete();
        rx_start_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (tx_line !== 1'b1 || busy !== 1'b0 || grant_id !== 2'd0 || req_ready !== 4'b0) begin
                n_errors++;
                $display("FAIL reset_values: tx=%b busy=%b gid=%0d ready=%b required 1/0/0/0000",
                         tx_line, busy, grant_id, req_ready);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            n_checks++;
            if (tx_line !== 1'b1 || busy !== 1'b0 || req_ready !== 4'b0) begin
                n_errors++;
                $display("FAIL reset_idle: tx=%b busy=%b ready=%b required 1/0/0000", tx_line, busy, req_ready);
            end
        end
    endtask

    task automatic test_single_byte();
        clear_logs();
        src_q[2].push_back(8'hA5);
        exp_q.push_back('{id: 2, data: 8'hA5});
        drive_inputs();
        wait_exp_empty(40, "single");
        n_checks++;
        if (acc_id_q.size() != 1 || rx_start_q.size() != 1 || acc_id_q[0] != 2) begin
            n_errors++;
            $display("FAIL single_accept: accepts=%0d frames=%0d required one accept of requester 2",
                     acc_id_q.size(), rx_start_q.size());
        end else begin
            n_checks++;
            if (rx_start_q[0] - acc_cyc_q[0] != 1) begin
                n_errors++;
                $display("FAIL single_latency: start bit %0d cycles after accept, required 1",
                         rx_start_q[0] - acc_cyc_q[0]);
            end
        end
        step();
        n_checks++;
        if (grant_id !== 2'd2 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL grant_hold: gid=%0d busy=%b required 2/0", grant_id, busy);
        end
    endtask

    task automatic test_round_robin();
        rst = 1'b1;
        step();
        step();
        clear_logs();
        for (int j = 0; j < 2; j++) begin
            for (int i = 0; i < N; i++) begin
                src_q[i].push_back(8'(8'h31 + 16 * i + 7 * j));
                exp_q.push_back('{id: i, data: 8'(8'h31 + 16 * i + 7 * j)});
            end
        end
        drive_inputs();
        rst = 1'b0;
        wait_exp_empty(8 * FL + 20, "rr");
        n_checks++;
        if (acc_id_q.size() != 8 || rx_start_q.size() != 8) begin
            n_errors++;
            $display("FAIL rr_count: accepts=%0d frames=%0d required 8/8", acc_id_q.size(), rx_start_q.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                n_checks++;
                if (acc_id_q[k] != k % N) begin
                    n_errors++;
                    $display("FAIL rr_order: accept %0d went to %0d, required %0d", k, acc_id_q[k], k % N);
                end
                if (k > 0) begin
                    n_checks++;
                    if (acc_cyc_q[k] - acc_cyc_q[k-1] != FL || rx_start_q[k] - rx_start_q[k-1] != FL) begin
                        n_errors++;
                        $display("FAIL rr_spacing: accept gap %0d start gap %0d, required %0d",
                                 acc_cyc_q[k] - acc_cyc_q[k-1], rx_start_q[k] - rx_start_q[k-1], FL);
                    end
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        int k = 0;
        int n0;
        clear_logs();
        src_q[1].push_back(8'hC3);
        drive_inputs();
        while (acc_id_q.size() == 0 && k < 20) begin
            step();
            k++;
        end
        n_checks++;
        if (acc_id_q.size() == 0) begin
            n_errors++;
            $display("FAIL midrst_accept: no accept of requester 1 within 20 cycles");
        end
        n0 = acc_id_q.size();
        src_q[0].push_back(8'h5A);
        src_q[3].push_back(8'h96);
        drive_inputs();
        for (int i = 0; i < 5; i++) step();
        n_checks++;
        if (acc_id_q.size() != n0 || tx_line !== 1'b0) begin
            n_errors++;
            $display("FAIL midrst_bit4: accepts=%0d tx=%b required %0d accepts and bit4=0",
                     acc_id_q.size(), tx_line, n0);
        end
        rst = 1'b1;
        #3;
        n_checks++;
        if (req_ready !== 4'b0) begin
            n_errors++;
            $display("FAIL midrst_no_accept: req_ready=%b required 0000 in reset cycle", req_ready);
        end
        step();
        n_checks++;
        if (tx_line !== 1'b1 || busy !== 1'b0 || grant_id !== 2'd0) begin
            n_errors++;
            $display("FAIL midrst_abort: tx=%b busy=%b gid=%0d required 1/0/0", tx_line, busy, grant_id);
        end
        rst = 1'b0;
        exp_q.push_back('{id: 0, data: 8'h5A});
        exp_q.push_back('{id: 3, data: 8'h96});
        wait_exp_empty(3 * FL, "midrst");
        n_checks++;
        if (acc_id_q.size() != n0 + 2 || acc_id_q[n0] != 0 || acc_id_q[n0+1] != 3) begin
            n_errors++;
            $display("FAIL midrst_order: %0d accepts after reset, required requester 0 then 3",
                     acc_id_q.size() - n0);
        end
    endtask

    task automatic test_back_to_back();
        clear_logs();
        src_q[1].push_back(8'h07);
        src_q[1].push_back(8'h07);
        exp_q.push_back('{id: 1, data: 8'h07});
        exp_q.push_back('{id: 1, data: 8'h07});
        drive_inputs();
        wait_exp_empty(3 * FL, "b2b");
        n_checks++;
        if (acc_id_q.size() != 2 || rx_start_q.size() != 2) begin
            n_errors++;
            $display("FAIL b2b_count: accepts=%0d frames=%0d required 2/2", acc_id_q.size(), rx_start_q.size());
        end else begin
            n_checks++;
            if (acc_cyc_q[1] - acc_cyc_q[0] != FL || rx_start_q[1] - rx_start_q[0] != FL) begin
                n_errors++;
                $display("FAIL b2b_spacing: accept gap %0d start gap %0d, required %0d",
                         acc_cyc_q[1] - acc_cyc_q[0], rx_start_q[1] - rx_start_q[0], FL);
            end
        end
    endtask

    task automatic test_bit_stretch();
        logic       bitq[$];
        logic [7:0] b = 8'h01;
        logic       e;
        @(negedge clk);
        n_checks++;
        if (s_tx !== 1'b1 || s_busy !== 1'b0 || s_ready !== 1'b0 || s_gid !== 1'b0) begin
            n_errors++;
            $display("FAIL slow_reset: tx=%b busy=%b ready=%b gid=%b required 1/0/0/0", s_tx, s_busy, s_ready, s_gid);
        end
        @(posedge clk);
        #1;
        s_rst   = 1'b0;
        s_valid = 1'b1;
        s_data  = b;
        for (int r = 0; r < SLOW_BC; r++) bitq.push_back(1'b0);
        for (int k = 0; k < 8; k++)
            for (int r = 0; r < SLOW_BC; r++) bitq.push_back(b[k]);
`ifdef SERIAL_TX_PARITY_EN
        for (int r = 0; r < SLOW_BC; r++) bitq.push_back(^b);
`endif
        for (int r = 0; r < SLOW_BC; r++) bitq.push_back(1'b1);
        @(negedge clk);
        n_checks++;
        if (s_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL slow_ready: ready=%b required 1 for single requester", s_ready);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_data  = 8'hFF;
        for (int c = 0; c < SLOW_BC * FL; c++) begin
            @(negedge clk);
            e = bitq.pop_front();
            n_checks++;
            if (s_tx !== e || s_busy !== 1'b1) begin
                n_errors++;
                $display("FAIL slow_bit: frame cycle %0d tx=%b busy=%b required %b/1", c, s_tx, s_busy, e);
            end
        end
        @(negedge clk);
        n_checks++;
        if (s_tx !== 1'b1 || s_busy !== 1'b0 || s_gid !== 1'b0) begin
            n_errors++;
            $display("FAIL slow_end: tx=%b busy=%b gid=%b required 1/0/0 after %0d cycles",
                     s_tx, s_busy, s_gid, SLOW_BC * FL);
        end
    endtask

    initial begin
        rst     = 1'b1;
        s_rst   = 1'b1;
        s_valid = 1'b0;
        s_data  = 8'h00;
        drive_inputs();
        test_reset();
        test_single_byte();
        test_round_robin();
        test_mid_reset();
        test_back_to_back();
        test_bit_stretch();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/serial_tx_arbiter.md
# serial_tx_arbiter

Shares one serial byte-frame transmitter among `NUM_REQ` byte producers. Requesters present bytes on valid/ready handshakes, and a round-robin arbiter grants one at a time. The granted byte is serialised as an idle-high frame on `tx_line`: start bit 0, eight data bits LSB first, stop bit 1. The block sits between the on-chip byte sources and the single serial output pin.

## Interface
- `NUM_REQ`, default 4: number of requesters; legal range 1..16.
- `BIT_CYCLES`, default 1: clock cycles per serial bit; must be ≥ 1.
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst`  input  1: reset; synchronous and active-high.
- `req_valid`  input  `NUM_REQ`: bit i set means requester i holds a byte.
- `req_data`  input  `NUM_REQ*8`: byte of requester i at bits [8i+7:8i].
- `req_ready`  output  `NUM_REQ`: one-hot accept; a byte transfers when `req_valid[i]` and `req_ready[i]` are both high.
- `tx_line`  output  1: registered serial output; high when idle.
- `busy`  output  1: registered; high while a frame is on the line.
- `grant_id`  output  `$clog2(NUM_REQ)` (min 1): registered index of the requester whose frame is being sent.

## Operation
- **States:** IDLE, START, DATA, STOP; PARITY is added when configured.
- **Bit timing:** each non-IDLE state lasts `BIT_CYCLES` cycles per bit, counted by a bit-cycle counter.
- **DATA state:** lasts 8 bits; a 3-bit index selects `shift_byte[idx]`, with idx running 0..7.
- **Arbitration:**
  - Round-robin, starting from `last_grant+1` modulo `NUM_REQ`.
  - The first requester with valid set wins.
  - After reset, requester 0 has top priority, because `last_grant` resets to `NUM_REQ-1`.
- **Accept window:**
  - Open in any IDLE cycle.
  - Also open on the final cycle of STOP, which allows back-to-back frames with no idle gap.
- **Accept behaviour:**
  - `req_ready` is combinational: the winner's bit is set only inside the window and only when at least one valid is present.
  - On accept, latch the winner's byte into `shift_byte`, update `last_grant`, and enter START.
- **Outside the window:** `req_ready` is all zeros. Valid may be held high indefinitely without effect.
- **Frame completion:** at the end of STOP, go to IDLE if nothing was accepted in that cycle.
- **`tx_line` values by state:** IDLE → 1, START → 0, DATA → `shift_byte[idx]`, STOP → 1.
- **`busy`:** high from the first START cycle through the last STOP cycle.
- **`grant_id`:** updates on accept; holds its value during IDLE.
- **Single requester (`NUM_REQ` = 1):** the arbiter degenerates to a pass-through of requester 0.
- **Reset mid-frame:** the frame is aborted. On the next cycle `tx_line` = 1, `busy` = 0, state = IDLE, and no accept occurs in the reset cycle.

## Timing
- **Reset values:** `tx_line` = 1, `busy` = 0, `grant_id` = 0, `req_ready` = 0 while `rst` is high.
- **Latency:** accept at cycle T puts the start bit on `tx_line` from T+1 for `BIT_CYCLES` cycles.
- **Data bits:** data bit k occupies cycles T+1+(1+k)·`BIT_CYCLES` onward, for `BIT_CYCLES` cycles each.
- **Frame length:** 10·`BIT_CYCLES` cycles; 11·`BIT_CYCLES` cycles with parity.
- **Back-to-back frames:**
  - The next start bit immediately follows the last stop cycle.
  - The sustained rate is one byte per frame length.
- **Simultaneous requests:** all `NUM_REQ` requesting continuously are served in strict rotation 0,1,2,…; each waits at most `NUM_REQ-1` frames.
- **Request arriving mid-frame:** it is not accepted until the accept window.
- **Input stability:** `req_data` must be stable only in the accept cycle.

## Configuration
- **Macro:** `SERIAL_TX_PARITY_EN`.
- **Defined:**
  - A PARITY state of `BIT_CYCLES` cycles is inserted between DATA and STOP.
  - It drives even parity, the XOR of the eight data bits.
  - The frame is 11 bits.
- **Undefined:** the PARITY state, its logic and its encoding are absent, and the frame is 10 bits.

## Structure
- **Shared package `serial_tx_pkg`:**
  - State enum typedef.
  - Constants `FRAME_DATA_BITS` = 8, `START_BIT` = 0, `STOP_BIT` = 1, `IDLE_LEVEL` = 1.
- **Sub-module `rr_arbiter`:**
  - Combinational round-robin grant from a request vector and a `last_grant` input.
  - Outputs a one-hot grant, the grant index and `any_req`.
- **Top level:** the frame FSM, counters and shift register stay in the top module.

## Test plan
- **Reset idle:**
  - Stimulus: assert `rst` 3 cycles, then release with no valids.
  - Required: `tx_line` = 1, `busy` = 0, `req_ready` = 0 for 20 cycles.
- **Single byte:**
  - Stimulus: `BIT_CYCLES`=1, requester 2 sends 0xA5.
  - Required: `tx_line` shows 0,1,0,1,0,0,1,0,1,1 starting one cycle after accept; `grant_id` = 2.
- **Round-robin:**
  - Stimulus: `NUM_REQ`=4, all four valid continuously from reset.
  - Required: accepts occur in order 0,1,2,3,0, exactly 10 cycles apart, with no idle gap.
- **Bit stretching:**
  - Stimulus: `BIT_CYCLES`=3, byte 0x01.
  - Required: start bit low for 3 cycles, then bit0 high for 3 cycles; frame spans 30 cycles.
- **Mid-frame reset:**
  - Stimulus: assert `rst` during data bit 4.
  - Required: the next cycle has `tx_line` = 1 and `busy` = 0; a valid held throughout is re-accepted only after reset release, beginning with requester 0.
- **Parity:**
  - Stimulus: `SERIAL_TX_PARITY_EN` defined, byte 0x07.
  - Required: parity bit = 1 after bit7, then stop bit; back-to-back frames are spaced 11 cycles apart.
